obi_pinmux_responder: RTL and testbench
=======================================

Name: obi_pinmux_responder

Overview:
OBI responder (subordinate) for the SoC's pinmux/GPIO region. The SoC core is the OBI initiator; this block sits on its external OBI port and decodes the region with address bits [31:24] = 0x0F. It holds the GPIO output, output-enable and pin-select registers, synchronises pad inputs, and routes each pad to either GPIO or a peripheral. It accepts one outstanding transaction at a time, with a configurable grant latency.

Parameters:
NUM_PINS, 8, number of pads (1..32)
GNT_WAIT, 0, idle cycles between accepting a request and asserting gnt (0..15)
REGION, 8'h0F, value of addr[31:24] that selects this block

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
obi_req_i  in  1  OBI request
obi_gnt_o  out  1  OBI grant, one-cycle pulse
obi_addr_i  in  32  byte address
obi_we_i  in  1  1=write
obi_be_i  in  4  byte enables
obi_wdata_i  in  32  write data
obi_rvalid_o  out  1  response valid, one-cycle pulse
obi_rdata_o  out  32  read data, valid only with rvalid
periph_o  in  NUM_PINS  peripheral output values
periph_oe_i  in  NUM_PINS  peripheral output enables
periph_i  out  NUM_PINS  synchronised pad inputs to peripherals
pad_o  out  NUM_PINS  pad output value
pad_oe_o  out  NUM_PINS  pad output enable
pad_i  in  NUM_PINS  raw pad input

Behaviour:
- Single clock clk_i. Synchronous active-high reset rst_i.
- Register map, decoded from addr[7:2]; the block ignores addr[23:8] and addr[1:0]:
  - 0x00 GPIO_OUT: RW
  - 0x04 GPIO_OE: RW
  - 0x08 GPIO_IN: RO, synchronised pads
  - 0x0C PIN_SEL: RW, 1=peripheral, 0=GPIO
  - 0x10 SCRATCH: RW, full 32 bits
- Register bits at and above NUM_PINS read 0 and ignore writes.
- Unmapped offsets read 0 and ignore writes. They still get a normal gnt/rvalid.
- Writes honour obi_be_i per byte. be=0 writes nothing but still completes.
- FSM states: IDLE, WAIT, GNT, RESP, ARM.
  - IDLE: if obi_req_i && addr[31:24]==REGION, go to WAIT (GNT_WAIT>0) or GNT (GNT_WAIT=0). Requests to other regions are ignored with no gnt.
  - WAIT: a counter loads GNT_WAIT-1 on entry and decrements to 0, then goes to GNT. If req drops during WAIT, return to IDLE with no gnt.
  - GNT: obi_gnt_o=1 for exactly 1 cycle. Addr, we, be and wdata are sampled this cycle. A write updates its register at the end of this cycle. Read data (the pre-write value for a write) is latched. Next state RESP.
  - RESP: obi_rvalid_o=1 for exactly 1 cycle. obi_rdata_o = latched read data; for writes it is 0. Next state ARM.
  - ARM: wait until obi_req_i is sampled 0, then go to IDLE. This prevents the initiator's registered grant path from causing a stale request to be re-accepted. If req is already 0 in RESP, ARM still lasts one cycle.
- Latency with GNT_WAIT=0: req seen in cycle n → gnt in n+1 → rvalid in n+2. Each GNT_WAIT adds 1 cycle.
- obi_rdata_o = 0 whenever rvalid=0.
- Pad input synchronisation: 2-flop synchroniser on pad_i. GPIO_IN and periph_i both take the second flop, so a pad change is visible 2 cycles later.
- Pad mux, per pin i, combinational from registers:
  - pad_o[i] = PIN_SEL[i] ? periph_o[i] : GPIO_OUT[i]
  - pad_oe_o[i] = PIN_SEL[i] ? periph_oe_i[i] : GPIO_OE[i]
- Reset values:
  - Registers: all 0, so every pad is GPIO input-only and pad_oe_o=0.
  - Synchroniser flops: 0.
  - FSM: IDLE.
  - Outputs: obi_gnt_o=0, obi_rvalid_o=0, obi_rdata_o=0.
- Reset mid-transaction (in WAIT, GNT or RESP) aborts it. No rvalid is issued, and a write in GNT is not applied if rst_i is high that cycle.
- Simultaneous events:
  - A write to GPIO_OUT in the same cycle as a PIN_SEL change: both take effect together at the edge. The pad mux uses the new values from the next cycle.
  - Writes to GPIO_IN are ignored. A read returns the synchroniser value sampled in the GNT cycle.

Test Plan:
1. Reset, GNT_WAIT=0 → gnt=0, rvalid=0, pad_oe_o=0x00. Read 0x0F000008 with pad_i=0xA5 held for 3 cycles → gnt 1 cycle after req, rvalid next cycle, rdata=0x000000A5.
2. Write 0x0F000000 data 0x3C be=4'b0001, write 0x0F000004 data 0xFF → pad_o=0x3C, pad_oe_o=0xFF. Each write returns rvalid with rdata=0.
3. PIN_SEL=0xF0, periph_o=0xAA, periph_oe_i=0x0F, GPIO_OUT=0x3C, GPIO_OE=0xFF → pad_o=0xAC, pad_oe_o=0x0F.
4. GNT_WAIT=3: req held high → gnt exactly 4 cycles after req seen; req kept high for 2 cycles after rvalid → no second gnt until req goes low and high again.
5. Request to 0x0A000000 → no gnt ever. Read 0x0F000040 → gnt and rvalid normal, rdata=0. SCRATCH write 0xDEADBEEF with be=4'b0110 over 0 → reads 0x00ADBE00.
6. Assert rst_i in the cycle after req is accepted (WAIT state, GNT_WAIT=2) → no gnt, no rvalid, registers 0, FSM accepts a fresh request afterwards.

Source files
------------

// File: rtl/obi_pinmux_responder.sv
// obi_pinmux_responder
//
// OBI subordinate for the pinmux/GPIO region. It decodes requests whose
// address bits [31:24] equal REGION and serves one transaction at a time.
// It holds the GPIO output, output-enable, pin-select and scratch registers.
// It synchronises pad inputs and routes each pad either to GPIO or to a
// peripheral.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   obi_req_i           request from the initiator
//   obi_gnt_o           one-cycle grant pulse
//   obi_addr_i          byte address; [31:24] region, [7:2] register offset
//   obi_we_i            1 = write
//   obi_be_i            byte enables for writes
//   obi_wdata_i         write data
//   obi_rvalid_o        one-cycle response pulse
//   obi_rdata_o         read data, zero whenever rvalid is low
//   periph_o            peripheral output values (into this block)
//   periph_oe_i         peripheral output enables
//   periph_i            synchronised pad inputs handed to peripherals
//   pad_o, pad_oe_o     pad output value and enable after the pin mux
//   pad_i               raw asynchronous pad inputs
//
// Register map (offset = addr[7:2] * 4):
//   0x00 GPIO_OUT  0x04 GPIO_OE  0x08 GPIO_IN (RO)  0x0C PIN_SEL  0x10 SCRATCH
module obi_pinmux_responder #(
    parameter int unsigned NUM_PINS = 8,
    parameter int unsigned GNT_WAIT = 0,
    parameter logic [7:0]  REGION   = 8'h0F
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                obi_req_i,
    output logic                obi_gnt_o,
    input  logic [31:0]         obi_addr_i,
    input  logic                obi_we_i,
    input  logic [3:0]          obi_be_i,
    input  logic [31:0]         obi_wdata_i,
    output logic                obi_rvalid_o,
    output logic [31:0]         obi_rdata_o,
    input  logic [NUM_PINS-1:0] periph_o,
    input  logic [NUM_PINS-1:0] periph_oe_i,
    output logic [NUM_PINS-1:0] periph_i,
    output logic [NUM_PINS-1:0] pad_o,
    output logic [NUM_PINS-1:0] pad_oe_o,
    input  logic [NUM_PINS-1:0] pad_i
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        GNT  = 3'd2,
        RESP = 3'd3,
        ARM  = 3'd4
    } state_e;

    localparam logic [5:0] OFF_OUT = 6'h00;
    localparam logic [5:0] OFF_OE  = 6'h01;
    localparam logic [5:0] OFF_IN  = 6'h02;
    localparam logic [5:0] OFF_SEL = 6'h03;
    localparam logic [5:0] OFF_SCR = 6'h04;

    // Only selected when GNT_WAIT > 0, so the wrap at GNT_WAIT = 0 never matters.
    localparam logic [3:0] WAIT_LOAD = (GNT_WAIT > 0) ? 4'(GNT_WAIT - 1) : 4'd0;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NUM_PINS-1:0] gpio_out_q, gpio_oe_q, pin_sel_q;
    logic [NUM_PINS-1:0] sync1_q, sync2_q;
    logic [31:0]         scratch_q;
    logic [31:0]         rdata_q;
    logic [31:0]         read_val;
    logic [31:0]         write_val;
    logic [5:0]          offset;
    logic                region_hit;
    logic                unused_addr;

    assign offset      = obi_addr_i[7:2];
    assign region_hit  = (obi_addr_i[31:24] == REGION);
    assign unused_addr = ^{obi_addr_i[23:8], obi_addr_i[1:0]};

    // Current value of the addressed register, zero-extended to 32 bits.
    // Unmapped offsets read as zero.
    always_comb begin
        read_val = '0;
        case (offset)
            OFF_OUT: read_val[NUM_PINS-1:0] = gpio_out_q;
            OFF_OE:  read_val[NUM_PINS-1:0] = gpio_oe_q;
            OFF_IN:  read_val[NUM_PINS-1:0] = sync2_q;
            OFF_SEL: read_val[NUM_PINS-1:0] = pin_sel_q;
            OFF_SCR: read_val               = scratch_q;
            default: read_val               = '0;
        endcase
    end

    // Byte-enable merge of the write data over the register's current value,
    // so disabled bytes keep their contents.
    always_comb begin
        write_val = read_val;
        for (int b = 0; b < 4; b++) begin
            if (obi_be_i[b]) begin
                write_val[8*b +: 8] = obi_wdata_i[8*b +: 8];
            end
        end
    end

    // Next-state and bus outputs. ARM waits for req to be sampled low, so a
    // request left high after the response is not taken as a new one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        obi_gnt_o    = 1'b0;
        obi_rvalid_o = 1'b0;
        obi_rdata_o  = '0;
        case (state_q)
            IDLE: begin
                if (obi_req_i && region_hit) begin
                    if (GNT_WAIT > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = GNT;
                    end
                end
            end
            WAIT: begin
                if (!obi_req_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = GNT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GNT: begin
                obi_gnt_o = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                obi_rvalid_o = 1'b1;
                obi_rdata_o  = rdata_q;
                state_d      = ARM;
            end
            ARM: begin
                if (!obi_req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and pad synchroniser. Reset aborts any transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
        end
    end

    // Register file. The access happens in the grant cycle. Read data is
    // latched there, and a write returns zero in its response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gpio_out_q <= '0;
            gpio_oe_q  <= '0;
            pin_sel_q  <= '0;
            scratch_q  <= '0;
            rdata_q    <= '0;
        end else if (state_q == GNT) begin
            rdata_q <= obi_we_i ? 32'h0 : read_val;
            if (obi_we_i) begin
                case (offset)
                    OFF_OUT: gpio_out_q <= write_val[NUM_PINS-1:0];
                    OFF_OE:  gpio_oe_q  <= write_val[NUM_PINS-1:0];
                    OFF_SEL: pin_sel_q  <= write_val[NUM_PINS-1:0];
                    OFF_SCR: scratch_q  <= write_val;
                    default: ;
                endcase
            end
        end
    end

    assign periph_i = sync2_q;
    assign pad_o    = (pin_sel_q & periph_o)    | (~pin_sel_q & gpio_out_q);
    assign pad_oe_o = (pin_sel_q & periph_oe_i) | (~pin_sel_q & gpio_oe_q);

endmodule

// File: tb/tb_obi_pinmux_responder.sv
// tb_obi_pinmux_responder
//
// Directed bench for obi_pinmux_responder. The bench instantiates three
// copies of the block with GNT_WAIT set to 0, 3 and 2 (index 0, 1 and 2).
// The copies share the address, data, pad and peripheral inputs. Each copy
// has its own request line. Inputs change 1 time unit after a rising edge,
// and outputs are sampled at the same point.
module tb_obi_pinmux_responder;

    localparam int NP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic [31:0]   addr;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [NP-1:0] pad_i;
    logic [NP-1:0] periph_o;
    logic [NP-1:0] periph_oe;

    logic [2:0]    gnt;
    logic [2:0]    rvalid;
    logic [31:0]   rdata     [3];
    logic [NP-1:0] periph_in [3];
    logic [NP-1:0] pad_o_w   [3];
    logic [NP-1:0] pad_oe_w  [3];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        obi_pinmux_responder #(
            .NUM_PINS (NP),
            .GNT_WAIT ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
            .REGION   (8'h0F)
        ) dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .obi_req_i    (req[g]),
            .obi_gnt_o    (gnt[g]),
            .obi_addr_i   (addr),
            .obi_we_i     (we),
            .obi_be_i     (be),
            .obi_wdata_i  (wdata),
            .obi_rvalid_o (rvalid[g]),
            .obi_rdata_o  (rdata[g]),
            .periph_o     (periph_o),
            .periph_oe_i  (periph_oe),
            .periph_i     (periph_in[g]),
            .pad_o        (pad_o_w[g]),
            .pad_oe_o     (pad_oe_w[g]),
            .pad_i        (pad_i)
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction on copy d. The task reports the grant latency in
    // cycles (-1 on timeout), whether rvalid came the cycle after gnt, and
    // the read data. It leaves the copy back in IDLE.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic w,
                                 input logic [3:0] b, input logic [31:0] wd,
                                 output int lat, output logic rv, output logic [31:0] rd);
        addr   = a;
        we     = w;
        be     = b;
        wdata  = wd;
        req[d] = 1'b1;
        lat    = -1;
        rv     = 1'b0;
        rd     = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (gnt[d]) begin
                lat = c;
                break;
            end
        end
        req[d] = 1'b0;
        if (lat > 0) begin
            step();
            rv = rvalid[d];
            rd = rdata[d];
            step();
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; addr = '0; we = 1'b0; be = '0; wdata = '0;
        pad_i = '0; periph_o = '0; periph_oe = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        tests_run++;
        if (gnt !== 3'b000) begin
            tests_failed++; $display("[TB] FAIL reset_gnt: got %b expected 000", gnt);
        end
        tests_run++;
        if (rvalid !== 3'b000) begin
            tests_failed++; $display("[TB] FAIL reset_rvalid: got %b expected 000", rvalid);
        end
        tests_run++;
        if (rdata[0] !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata[0]);
        end
        tests_run++;
        if (pad_oe_w[0] !== 8'h00 || pad_oe_w[1] !== 8'h00 || pad_oe_w[2] !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL reset_pad_oe: got %h/%h/%h expected 00",
                                     pad_oe_w[0], pad_oe_w[1], pad_oe_w[2]);
        end
    endtask

    task automatic test_gpio_in();
        int lat; logic rv; logic [31:0] rd;
        pad_i = 8'hA5;
        step();
        tests_run++;
        if (periph_in[0] !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL sync_1cyc: got %h expected 00", periph_in[0]);
        end
        step();
        tests_run++;
        if (periph_in[0] !== 8'hA5) begin
            tests_failed++; $display("[TB] FAIL sync_2cyc: got %h expected a5", periph_in[0]);
        end
        step();
        applyStimulus(0, 32'h0F00_0008, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++; $display("[TB] FAIL gpio_in_lat: got %0d expected 1", lat);
        end
        tests_run++;
        if (rv !== 1'b1 || rd !== 32'h0000_00A5) begin
            tests_failed++; $display("[TB] FAIL gpio_in_read: got rv=%b %h expected rv=1 000000a5", rv, rd);
        end
        applyStimulus(0, 32'h0F00_0008, 1'b1, 4'hF, 32'h0, lat, rv, rd);
        applyStimulus(0, 32'h0F00_0008, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        tests_run++;
        if (rd !== 32'h0000_00A5) begin
            tests_failed++; $display("[TB] FAIL gpio_in_ro: got %h expected 000000a5", rd);
        end
    endtask

    task automatic test_gpio_write();
        int lat; logic rv; logic [31:0] rd;
        applyStimulus(0, 32'h0F00_0000, 1'b1, 4'b0001, 32'h1234_563C, lat, rv, rd);
        tests_run++;
        if (lat !== 1 || rv !== 1'b1 || rd !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL out_write_resp: got lat=%0d rv=%b %h expected 1/1/0", lat, rv, rd);
        end
        applyStimulus(0, 32'h0F00_0004, 1'b1, 4'hF, 32'h0000_00FF, lat, rv, rd);
        tests_run++;
        if (rv !== 1'b1 || rd !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL oe_write_resp: got rv=%b %h expected 1/0", rv, rd);
        end
        tests_run++;
        if (pad_o_w[0] !== 8'h3C || pad_oe_w[0] !== 8'hFF) begin
            tests_failed++; $display("[TB] FAIL gpio_pads: got %h/%h expected 3c/ff", pad_o_w[0], pad_oe_w[0]);
        end
        applyStimulus(0, 32'h0F00_0000, 1'b1, 4'b0000, 32'h0, lat, rv, rd);
        tests_run++;
        if (rv !== 1'b1 || pad_o_w[0] !== 8'h3C) begin
            tests_failed++; $display("[TB] FAIL be_zero: got rv=%b pad=%h expected 1/3c", rv, pad_o_w[0]);
        end
        applyStimulus(0, 32'h0F00_0000, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        tests_run++;
        if (rd !== 32'h0000_003C) begin
            tests_failed++; $display("[TB] FAIL out_readback: got %h expected 0000003c", rd);
        end
    endtask

    task automatic test_pin_mux();
        int lat; logic rv; logic [31:0] rd;
        periph_o  = 8'hAA;
        periph_oe = 8'h0F;
        applyStimulus(0, 32'h0F00_000C, 1'b1, 4'hF, 32'hFFFF_FFF0, lat, rv, rd);
        tests_run++;
        if (pad_o_w[0] !== 8'hAC || pad_oe_w[0] !== 8'h0F) begin
            tests_failed++; $display("[TB] FAIL pin_mux: got %h/%h expected ac/0f", pad_o_w[0], pad_oe_w[0]);
        end
        applyStimulus(0, 32'h0F00_000C, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        tests_run++;
        if (rd !== 32'h0000_00F0) begin
            tests_failed++; $display("[TB] FAIL sel_upper_bits: got %h expected 000000f0", rd);
        end
    endtask

    task automatic test_decode_and_scratch();
        int lat; logic rv; logic [31:0] rd; int seen;
        addr = 32'h0A00_0000; we = 1'b0; be = 4'hF;
        req[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (gnt[0] || rvalid[0]) seen++;
        end
        req[0] = 1'b0;
        step();
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("[TB] FAIL other_region: got %0d responses expected 0", seen);
        end
        applyStimulus(0, 32'h0F00_0040, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        tests_run++;
        if (lat !== 1 || rv !== 1'b1 || rd !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL unmapped: got lat=%0d rv=%b %h expected 1/1/0", lat, rv, rd);
        end
        applyStimulus(0, 32'h0F12_340B, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        tests_run++;
        if (rd !== 32'h0000_00A5) begin
            tests_failed++; $display("[TB] FAIL ignored_addr_bits: got %h expected 000000a5", rd);
        end
        applyStimulus(0, 32'h0F00_0010, 1'b1, 4'b0110, 32'hDEAD_BEEF, lat, rv, rd);
        applyStimulus(0, 32'h0F00_0010, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        tests_run++;
        if (rd !== 32'h00AD_BE00) begin
            tests_failed++; $display("[TB] FAIL scratch_be: got %h expected 00adbe00", rd);
        end
    endtask

    task automatic test_grant_wait();
        int lat; int seen;
        addr = 32'h0F00_0010; we = 1'b0; be = 4'hF;
        req[1] = 1'b1;
        step();
        step();
        req[1] = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (gnt[1]) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("[TB] FAIL wait_abort: got %0d grants expected 0", seen);
        end
        req[1] = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (gnt[1]) begin
                lat = c;
                break;
            end
        end
        tests_run++;
        if (lat !== 4) begin
            tests_failed++; $display("[TB] FAIL wait3_lat: got %0d expected 4", lat);
        end
        step();
        tests_run++;
        if (rvalid[1] !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL wait3_rvalid: got %b expected 1", rvalid[1]);
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (gnt[1] || rvalid[1]) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("[TB] FAIL arm_hold: got %0d pulses expected 0", seen);
        end
        req[1] = 1'b0;
        step();
        req[1] = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (gnt[1]) begin
                lat = c;
                break;
            end
        end
        req[1] = 1'b0;
        tests_run++;
        if (lat !== 4) begin
            tests_failed++; $display("[TB] FAIL rearm_lat: got %0d expected 4", lat);
        end
        step();
        step();
        step();
    endtask

    task automatic test_reset_abort();
        int lat; logic rv; logic [31:0] rd; int seen; int gnt_seen;
        applyStimulus(2, 32'h0F00_0004, 1'b1, 4'hF, 32'h0000_00FF, lat, rv, rd);
        tests_run++;
        if (lat !== 3 || pad_oe_w[2] !== 8'hFF) begin
            tests_failed++; $display("[TB] FAIL wait2_write: got lat=%0d oe=%h expected 3/ff", lat, pad_oe_w[2]);
        end
        addr = 32'h0F00_0000; we = 1'b1; be = 4'hF; wdata = 32'h55;
        req[2] = 1'b1;
        step();
        rst = 1'b1;
        req[2] = 1'b0;
        step();
        rst = 1'b0;
        seen = (gnt[2] || rvalid[2]) ? 1 : 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (gnt[2] || rvalid[2]) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("[TB] FAIL rst_in_wait: got %0d pulses expected 0", seen);
        end
        tests_run++;
        if (pad_oe_w[2] !== 8'h00 || pad_o_w[2] !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL rst_regs: got %h/%h expected 00/00", pad_o_w[2], pad_oe_w[2]);
        end
        applyStimulus(2, 32'h0F00_0004, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        tests_run++;
        if (lat !== 3 || rv !== 1'b1 || rd !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL fresh_req: got lat=%0d rv=%b %h expected 3/1/0", lat, rv, rd);
        end
        addr = 32'h0F00_0000; we = 1'b1; be = 4'hF; wdata = 32'h55;
        req[2] = 1'b1;
        gnt_seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (gnt[2]) begin
                gnt_seen = 1;
                break;
            end
        end
        rst = 1'b1;
        req[2] = 1'b0;
        step();
        rst = 1'b0;
        tests_run++;
        if (gnt_seen !== 1 || rvalid[2] !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL rst_in_gnt: got gnt=%0d rv=%b expected 1/0", gnt_seen, rvalid[2]);
        end
        tests_run++;
        if (pad_o_w[2] !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL rst_in_gnt_write: got %h expected 00", pad_o_w[2]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_gpio_in();
        test_gpio_write();
        test_pin_mux();
        test_decode_and_scratch();
        test_grant_wait();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
